// File: rtl/seq_alu_core.sv
// seq_alu_core: multi-cycle unsigned ALU (add, sub, shift-add multiply,
// restoring divide) with a start/busy/done handshake and registered results.
//
// Handshake: a request is accepted on any rising edge where start=1 and
// busy=0; a, b and op are captured on that edge and never looked at again
// until the next acceptance. busy is high from the cycle after acceptance
// up to and including the cycle before done. done is a one-cycle pulse that
// coincides with result/carry/zero/div_by_zero taking their new values.
// Because busy is low during the done cycle, a new start there is accepted.
module seq_alu_core #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 zero,
  output logic                 div_by_zero,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           fsm_state
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [1:0]           op_q, op_d;
  logic                 pend_q, pend_d;     // single-cycle op waiting to complete
  logic [2*WIDTH-1:0]   work_q, work_d;     // {hi, lo} iteration register
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 dbz_q, dbz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_diff;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_tmp;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;

  // Datapath for one multiply / divide iteration and the single-cycle ops
  always_comb begin
    accept   = start && !busy_q;
    add_sum  = {1'b0, a_q} + {1'b0, b_q};
    sub_diff = {1'b0, a_q} - {1'b0, b_q};
    // Shift-add: multiplier sits in the low half and shifts out LSB first,
    // the partial product grows into the high half with its carry kept.
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, (work_q[0] ? a_q : {WIDTH{1'b0}})};
    mul_next = {mul_sum, work_q[WIDTH-1:1]};
    // Restoring division: high half is the partial remainder, low half the
    // dividend shifting out MSB first while quotient bits shift in.
    div_tmp  = work_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_tmp - {1'b0, b_q};
    div_next = div_diff[WIDTH] ? {div_tmp[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
  end

  // Next-state logic: accept, iterate, and finalise results on completion
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    pend_d   = pend_q;
    work_d   = work_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
          case (op_q)
            OP_ADD: begin
              result_d = {{(WIDTH-1){1'b0}}, add_sum};
              carry_d  = add_sum[WIDTH];
              dbz_d    = 1'b0;
            end
            OP_SUB: begin
              result_d = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
              carry_d  = sub_diff[WIDTH];
              dbz_d    = 1'b0;
            end
            default: begin
              // Only divide-by-zero reaches here without iterating.
              result_d = {a_q, {WIDTH{1'b1}}};
              carry_d  = 1'b0;
              dbz_d    = 1'b1;
            end
          endcase
        end else if (accept) begin
          a_d    = a;
          b_d    = b;
          op_d   = op;
          busy_d = 1'b1;
          if (op == OP_MUL) begin
            state_d = S_MUL;
            cnt_d   = CNT_W'(WIDTH);
            work_d  = {{WIDTH{1'b0}}, b};
          end else if (op == OP_DIV && b != {WIDTH{1'b0}}) begin
            state_d = S_DIV;
            cnt_d   = CNT_W'(WIDTH);
            work_d  = {{WIDTH{1'b0}}, a};
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          work_d = (state_q == S_MUL) ? mul_next : div_next;
          cnt_d  = cnt_q - CNT_W'(1);
        end else begin
          result_d = work_q;
          carry_d  = 1'b0;
          dbz_d    = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (done_d) zero_d = (result_d == {(2*WIDTH){1'b0}});
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      pend_q   <= 1'b0;
      work_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      pend_q   <= pend_d;
      work_q   <= work_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result      = result_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fsm_state   = state_q;

endmodule
